// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
//   WB_XLEN    : register data width
//   WB_RAW     : register address width
//   wb_entry_t : one buffered write-back result {rd, data}
package wb_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_RAW  = 5;

  typedef struct packed {
    logic [WB_RAW-1:0]  rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for LSU write-backs waiting on the register-file write port.
// Full and empty are told apart by the occupancy count; pointers wrap
// modulo DEPTH. All entries and their valid bits are exported so the
// parent can search pending writes for operand bypass.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (flushes pointers/count)
//   push        : write push_entry at the tail (caller guarantees not full)
//   push_entry  : entry to enqueue
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : oldest entry
//   head_idx    : storage index of the oldest entry (age reference for entries)
//   count       : current occupancy, 0..DEPTH
//   not_full    : registered "occupancy != DEPTH", 0 while in reset
//   entries     : raw storage, indexed by physical slot
//   valid       : per-slot occupied flag
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH)-1:0]  head_idx,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      not_full,
  output wb_entry_t [DEPTH-1:0]     entries,
  output logic [DEPTH-1:0]          valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count    <= count_nxt;
      not_full <= (count_nxt != FULL);
    end
  end

  // Storage needs no reset: stale slots are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_entry;
    end
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, AW'(i) - rptr}) < count;
    end
  end

  assign head     = mem[rptr];
  assign head_idx = rptr;
  assign entries  = mem;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the CPU register file. Merges single-cycle ALU
// results and buffered LSU results onto the register file's one write port.
// The ALU normally has priority; a starvation counter stalls the ALU for one
// cycle after STARVE_MAX consecutive losses by a non-empty FIFO so the FIFO
// head is guaranteed to drain.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : byp_hit*/byp_data* report the youngest pending write to
//               byp_rs* (newest FIFO entry, older FIFO entries, then the
//               registered write port); rs 0 never hits
//   undefined : bypass outputs tied to 0
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data  : ALU result this cycle (rd 0 = no request)
//   alu_stall                  : registered; ALU result this cycle not taken
//   lsu_valid/lsu_ready        : LSU result handshake (see below)
//   lsu_rd/lsu_data            : LSU result (rd 0 is accepted and dropped)
//   RegWrite/Rd/Write_data     : registered register-file write port
//   fifo_count                 : LSU FIFO occupancy
//   byp_rs1/2, byp_hit1/2, byp_data1/2 : pending-write bypass lookup
//
// LSU handshake: a result transfers on a rising edge where lsu_valid and
// lsu_ready are both high. lsu_ready is registered and depends only on the
// FIFO occupancy, never on lsu_valid; it is low whenever the FIFO is full,
// including cycles in which the head is being popped.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  output logic                   alu_stall,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [4:0]             lsu_rd,
  input  logic [31:0]            lsu_data,
  output logic                   RegWrite,
  output logic [4:0]             Rd,
  output logic [31:0]            Write_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  input  logic [4:0]             byp_rs1,
  input  logic [4:0]             byp_rs2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [31:0]            byp_data1,
  output logic [31:0]            byp_data2
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic                  alu_req;
  logic                  fifo_nonempty;
  logic                  pop;
  logic                  push;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic [AW-1:0]         head_idx;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic [SW-1:0]         starve_cnt;

  // An ALU result aimed at x0 is not a request, and nothing is taken from
  // the ALU during the stall cycle, so the FIFO gets the port then.
  assign alu_req       = alu_valid && !alu_stall && (alu_rd != '0);
  assign fifo_nonempty = (fifo_count != '0);
  assign pop           = !alu_req && fifo_nonempty;
  // x0 LSU results complete the handshake but are never stored.
  assign push          = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign push_entry    = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_idx   (head_idx),
    .count      (fifo_count),
    .not_full   (lsu_ready),
    .entries    (fifo_entries),
    .valid      (fifo_valid)
  );

  // Starvation counter: counts ALU wins while the FIFO waits. Reaching the
  // limit clears it and raises alu_stall for the following cycle only.
  // When the FIFO is non-empty and nothing pops, the ALU necessarily won.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      alu_stall <= 1'b0;
      if (pop || !fifo_nonempty) begin
        starve_cnt <= '0;
      end else if (starve_cnt == STARVE_LIM - 1'b1) begin
        starve_cnt <= '0;
        alu_stall  <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
    end else begin
      RegWrite <= alu_req || pop;
      if (alu_req) begin
        Rd         <= alu_rd;
        Write_data <= alu_data;
      end else if (pop) begin
        Rd         <= head.rd;
        Write_data <= head.data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so that later (younger) matches overwrite
  // earlier ones; the write-port register is older than any FIFO entry.
  // Data reads 0 on a miss.
  always_comb begin
    byp_hit1  = RegWrite && (Rd == byp_rs1);
    byp_data1 = byp_hit1 ? Write_data : '0;
    byp_hit2  = RegWrite && (Rd == byp_rs2);
    byp_data2 = byp_hit2 ? Write_data : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (fifo_valid[head_idx + AW'(k)] &&
          (fifo_entries[head_idx + AW'(k)].rd == byp_rs1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = fifo_entries[head_idx + AW'(k)].data;
      end
      if (fifo_valid[head_idx + AW'(k)] &&
          (fifo_entries[head_idx + AW'(k)].rd == byp_rs2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = fifo_entries[head_idx + AW'(k)].data;
      end
    end
    if (byp_rs1 == '0) begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
    end
    if (byp_rs2 == '0) begin
      byp_hit2  = 1'b0;
      byp_data2 = '0;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_rs1, byp_rs2, head_idx, fifo_entries, fifo_valid};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a directed vector table, a bypass
// sequence and a randomized run checked against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;
  localparam int NRAND      = 3000;

`ifdef WB_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic [2:0]  fifo_count;
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Write_data (Write_data),
    .fifo_count (fifo_count),
    .byp_rs1    (byp_rs1),
    .byp_rs2    (byp_rs2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [36:0] exp_q[$];   // pending LSU results {rd, data}, oldest first
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_ready;
  logic        m_stall;
  int          m_losses;

  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        rdy;
    logic        stl;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                              input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ld, input logic we, input logic [4:0] rd,
                              input logic [31:0] wd, input logic [2:0] cnt,
                              input logic rdy, input logic stl);
    vec_t v;
    v.r = r;   v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.we = we; v.rd = rd; v.wd = wd;   v.cnt = cnt; v.rdy = rdy; v.stl = stl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] wd, input logic [2:0] cnt,
                             input logic rdy, input logic stl);
    check({tag, ".RegWrite"},   RegWrite,   we);
    check({tag, ".Rd"},         Rd,         rd);
    check({tag, ".Write_data"}, Write_data, wd);
    check({tag, ".fifo_count"}, fifo_count, cnt);
    check({tag, ".lsu_ready"},  lsu_ready,  rdy);
    check({tag, ".alu_stall"},  alu_stall,  stl);
  endtask

  task automatic check_byp(input string tag, input logic h1, input logic [31:0] d1,
                           input logic h2, input logic [31:0] d2);
    check({tag, ".byp_hit1"},  byp_hit1,  h1);
    check({tag, ".byp_data1"}, byp_data1, d1);
    check({tag, ".byp_hit2"},  byp_hit2,  h2);
    check({tag, ".byp_data2"}, byp_data2, d2);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ld);
    rst_n     = r;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
  endtask

  // ---------------- reference model ----------------
  // One clock edge of the write-back front end, expressed on a queue.
  task automatic model_step(input logic r, input logic av, input logic [4:0] ard,
                            input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                            input logic [31:0] ld);
    logic alu_req;
    logic do_pop;
    logic do_push;
    if (!r) begin
      exp_q.delete();
      m_we = 1'b0; m_rd = '0; m_wd = '0;
      m_ready = 1'b0; m_stall = 1'b0; m_losses = 0;
      return;
    end
    alu_req = av && !m_stall && (ard != 5'd0);
    do_pop  = !alu_req && (exp_q.size() != 0);
    do_push = lv && m_ready && (lrd != 5'd0);
    m_we = alu_req || do_pop;
    if (alu_req) begin
      m_rd = ard;
      m_wd = ad;
    end else if (do_pop) begin
      m_rd = exp_q[0][36:32];
      m_wd = exp_q[0][31:0];
    end
    m_stall = 1'b0;
    if (do_pop || exp_q.size() == 0) begin
      m_losses = 0;
    end else begin
      m_losses++;
      if (m_losses == STARVE_MAX) begin
        m_losses = 0;
        m_stall  = 1'b1;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({lrd, ld});
    m_ready = (exp_q.size() != DEPTH);
  endtask

  // Youngest pending value for rs: newest queued result, then write port.
  function automatic void model_byp(input logic [4:0] rs, output logic hit,
                                    output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (!BYP_EN || rs == 5'd0) return;
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k][36:32] == rs) begin
        hit  = 1'b1;
        data = exp_q[k][31:0];
        return;
      end
    end
    if (m_we && m_rd == rs) begin
      hit  = 1'b1;
      data = m_wd;
    end
  endfunction

  // ---------------- test ----------------
  logic        r_r;
  logic        r_av;
  logic [4:0]  r_ard;
  logic [31:0] r_ad;
  logic        r_lv;
  logic [4:0]  r_lrd;
  logic [31:0] r_ld;
  logic        e_h1;
  logic        e_h2;
  logic [31:0] e_d1;
  logic [31:0] e_d2;

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    byp_rs1 = '0;
    byp_rs2 = '0;

    //              r  av ard ad        lv lrd ld          we rd  wd          cnt rdy stl
    vecs[0]  = mk(0, 0, 0,  32'h0,    1, 7,  32'h1,    0, 0,  32'h0,    0, 0, 0);
    vecs[1]  = mk(0, 0, 0,  32'h0,    1, 7,  32'h1,    0, 0,  32'h0,    0, 0, 0);
    vecs[2]  = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    0, 1, 0);
    vecs[3]  = mk(1, 1, 5,  32'h2A,   0, 0,  32'h0,    1, 5,  32'h2A,   0, 1, 0);
    vecs[4]  = mk(1, 1, 0,  32'h99,   0, 0,  32'h0,    0, 5,  32'h2A,   0, 1, 0);
    vecs[5]  = mk(1, 0, 0,  32'h0,    1, 7,  32'hDEAD, 0, 5,  32'h2A,   1, 1, 0);
    vecs[6]  = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    1, 7,  32'hDEAD, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0,  32'h0,    1, 0,  32'h55,   0, 7,  32'hDEAD, 0, 1, 0);
    vecs[8]  = mk(1, 1, 1,  32'h101,  1, 10, 32'hA0,   1, 1,  32'h101,  1, 1, 0);
    vecs[9]  = mk(1, 1, 2,  32'h102,  1, 11, 32'hA1,   1, 2,  32'h102,  2, 1, 0);
    vecs[10] = mk(1, 1, 3,  32'h103,  1, 12, 32'hA2,   1, 3,  32'h103,  3, 1, 0);
    vecs[11] = mk(1, 1, 4,  32'h104,  1, 13, 32'hA3,   1, 4,  32'h104,  4, 0, 1);
    vecs[12] = mk(1, 1, 5,  32'h105,  1, 14, 32'hA4,   1, 10, 32'hA0,   3, 1, 0);
    vecs[13] = mk(1, 1, 5,  32'h105,  1, 14, 32'hA4,   1, 5,  32'h105,  4, 0, 0);
    vecs[14] = mk(1, 1, 6,  32'h106,  0, 0,  32'h0,    1, 6,  32'h106,  4, 0, 0);
    vecs[15] = mk(1, 1, 7,  32'h107,  0, 0,  32'h0,    1, 7,  32'h107,  4, 0, 1);
    vecs[16] = mk(1, 1, 8,  32'h108,  0, 0,  32'h0,    1, 11, 32'hA1,   3, 1, 0);
    vecs[17] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    1, 12, 32'hA2,   2, 1, 0);
    vecs[18] = mk(1, 1, 9,  32'h109,  0, 0,  32'h0,    1, 9,  32'h109,  2, 1, 0);
    vecs[19] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    1, 13, 32'hA3,   1, 1, 0);
    vecs[20] = mk(1, 0, 0,  32'h0,    1, 15, 32'hB5,   1, 14, 32'hA4,   1, 1, 0);
    vecs[21] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    1, 15, 32'hB5,   0, 1, 0);
    vecs[22] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    0, 15, 32'hB5,   0, 1, 0);
    vecs[23] = mk(1, 0, 0,  32'h0,    1, 20, 32'hC0,   0, 15, 32'hB5,   1, 1, 0);
    vecs[24] = mk(0, 1, 3,  32'h33,   0, 0,  32'h0,    0, 0,  32'h0,    0, 0, 0);
    vecs[25] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    0, 1, 0);
    vecs[26] = mk(1, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,  32'h0,    0, 1, 0);

    // Directed table: each row is held across one edge, then checked.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, vecs[i].wd,
                  vecs[i].cnt, vecs[i].rdy, vecs[i].stl);
    end

    // Bypass: two rd=3 results queued behind ALU traffic, youngest wins.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h11);
    byp_rs1 = 5'd3;
    byp_rs2 = 5'd0;
    @(posedge clk);
    #1;
    check_byp("bypA", BYP_EN, BYP_EN ? 32'h11 : 32'h0, 1'b0, 32'h0);

    @(negedge clk);
    drive(1'b1, 1'b1, 5'd4, 32'h45, 1'b1, 5'd3, 32'h22);
    @(posedge clk);
    #1;
    check_byp("bypB", BYP_EN, BYP_EN ? 32'h22 : 32'h0, 1'b0, 32'h0);
    byp_rs1 = 5'd9;
    byp_rs2 = 5'd4;
    #1;
    check_byp("bypB2", 1'b0, 32'h0, BYP_EN, BYP_EN ? 32'h45 : 32'h0);

    // Write port now holds rd=3 too, but the queued entries are younger.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    byp_rs1 = 5'd3;
    byp_rs2 = 5'd3;
    @(posedge clk);
    #1;
    check_byp("bypC", BYP_EN, BYP_EN ? 32'h22 : 32'h0, BYP_EN, BYP_EN ? 32'h22 : 32'h0);

    // Randomized run against the model, with a mid-run reset.
    r_av = 1'b0; r_ard = '0; r_ad = '0;
    for (int i = 0; i < NRAND; i++) begin
      @(negedge clk);
      r_r = !(i < 2 || i == 1500 || i == 1501);
      // A stalled ALU result is re-presented, as the pipeline would.
      if (!(r_r && m_stall && i >= 1)) begin
        r_av  = ($urandom_range(0, 3) != 0);
        r_ard = 5'($urandom_range(0, 7));
        r_ad  = $urandom;
      end
      r_lv  = ($urandom_range(0, 1) != 0);
      r_lrd = 5'($urandom_range(0, 7));
      r_ld  = $urandom;
      drive(r_r, r_av, r_ard, r_ad, r_lv, r_lrd, r_ld);
      byp_rs1 = 5'($urandom_range(0, 7));
      byp_rs2 = 5'($urandom_range(0, 7));
      #1;
      if (i >= 1) begin
        check_state($sformatf("rnd%0d", i), m_we, m_rd, m_wd,
                    3'(exp_q.size()), m_ready, m_stall);
        model_byp(byp_rs1, e_h1, e_d1);
        model_byp(byp_rs2, e_h2, e_d2);
        check_byp($sformatf("rnd%0d", i), e_h1, e_d1, e_h2, e_d2);
      end
      model_step(r_r, r_av, r_ard, r_ad, r_lv, r_lrd, r_ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end of the CPU register file. It merges completed results from the single-cycle ALU path and the variable-latency load/store unit (LSU) into the register file's single write port. LSU results wait in a small FIFO while the ALU has priority, and a starvation limit guarantees the FIFO eventually drains. It drives the register file's RegWrite/Rd/Write_data inputs from registers.

## Interface
- DEPTH, 4: LSU result FIFO entries; power of two, 2..16.
- STARVE_MAX, 3: consecutive lost arbitrations allowed to a non-empty FIFO before the ALU is stalled.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- alu_valid  in  1  ALU result present this cycle; no backpressure except alu_stall.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered; ALU result presented this cycle is not accepted.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- RegWrite  out  1  registered write enable to the register file.
- Rd  out  5  registered write address.
- Write_data  out  32  registered write data.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- byp_rs1, byp_rs2  in  5  decode-stage source indices for bypass lookup.
- byp_hit1, byp_hit2  out  1  pending write to that source exists.
- byp_data1, byp_data2  out  32  youngest pending value for that source.

## Operation
- FIFO handling:
  - lsu_ready = (fifo_count != DEPTH); there is no push-while-full, even when a pop occurs in the same cycle.
  - An accepted LSU result with lsu_rd==0 is consumed and discarded; it is not pushed.
- Arbitration, evaluated every cycle:
  - The ALU wins if alu_valid && !alu_stall && alu_rd!=0.
  - Otherwise the FIFO head is popped if the FIFO is non-empty.
  - Otherwise no write is issued.
- x0 handling: an ALU result with alu_rd==0 is treated as no request and the FIFO may pop that cycle.
- Registered write port: on the next edge the winner's rd/data are loaded into Rd/Write_data and RegWrite=1. With no winner, RegWrite=0 and Rd/Write_data hold their previous values.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears on any pop, and clears when the FIFO is empty.
  - When the counter reaches STARVE_MAX, alu_stall is registered high for exactly one cycle and the counter clears. In that cycle the FIFO wins unconditionally.
  - The pipeline must hold the ALU result during alu_stall. Any alu_valid seen while alu_stall is high is ignored.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged.
- Pop on a 1-entry FIFO with a simultaneous push: the new entry becomes the head next cycle.
- Reset mid-operation: the FIFO is flushed (pointers and count cleared), and any in-flight write and buffered results are lost.
- Reset values: RegWrite=0, Rd=0, Write_data=0, alu_stall=0, fifo_count=0, lsu_ready=0 during reset, and the starvation counter is 0. lsu_ready rises in the first cycle after rst_n deasserts.

## Timing
- ALU latency: alu_valid in cycle N gives RegWrite in cycle N+1. The register file captures the write at the end of N+1.
- LSU latency:
  - Minimum: transfer in N gives RegWrite in N+2 (push at end of N, pop decided in N+1).
  - Worst case with sustained ALU traffic: N+2+STARVE_MAX×(entries ahead+1).
- lsu_ready, fifo_count and alu_stall come from registers only. The bypass outputs are combinational from byp_rs* and state.
- FIFO pointers wrap modulo DEPTH; full and empty are distinguished by count.

## Configuration
- Macro: WB_BYPASS_EN.
- Defined:
  - byp_hit/byp_data search the registered write port (RegWrite && Rd==rs) and all FIFO entries.
  - The youngest match wins: newest FIFO entry first, then older FIFO entries, then the write-port register.
  - rs==0 never hits.
- Undefined: the bypass ports still exist; byp_hit* and byp_data* are tied to 0, and no comparator logic is generated.

## Structure
- Package wb_pkg holds:
  - Constants WB_XLEN=32 and WB_RAW=5.
  - Typedef wb_entry_t {logic [WB_RAW-1:0] rd; logic [WB_XLEN-1:0] data;}.
- Sub-module wb_fifo holds the storage, pointers and count for DEPTH wb_entry_t entries. It exposes all entries and their valid bits for the bypass search.
- The arbiter, starvation counter and output registers live in regfile_wb_arbiter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with lsu_valid=1 -> RegWrite=0, lsu_ready=0, fifo_count=0; lsu_ready=1 in the cycle after release.
- ALU only: alu_rd=5, alu_data=0x2A in cycle 10 -> RegWrite=1, Rd=5, Write_data=0x2A in cycle 11. alu_rd=0 -> no write.
- LSU only: push rd=7, data=0xDEAD in cycle 3 -> write in cycle 5. Push rd=0 -> lsu_ready stays 1, fifo_count stays 0.
- Full FIFO: four LSU pushes while the ALU is valid every cycle -> fifo_count=4, lsu_ready=0. The 5th push is refused until a pop occurs.
- Starvation, STARVE_MAX=3: FIFO non-empty with continuous ALU traffic -> alu_stall=1 on every 4th cycle, and the FIFO head is written in exactly that cycle.
- Bypass with WB_BYPASS_EN defined: FIFO holds rd=3 entries 0x11 then 0x22 and byp_rs1=3 -> byp_hit1=1, byp_data1=0x22. byp_rs2=0 -> byp_hit2=0.
